// File: rtl/dmux_rr_scheduler.sv
// rtl/dmux_rr_scheduler.sv - round-robin burst scheduler feeding a 1:8 demux
module dmux_rr_scheduler #(
    parameter int BURST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    input  logic [7:0] chan_en,
    output logic       data_in,
    output logic [2:0] sel,
    output logic       dmx_valid,
    output logic       frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

    state_t     state_q, state_d;
    logic [2:0] cur_q, cur_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic       data_in_q, data_in_d;
    logic [2:0] sel_q, sel_d;
    logic       dmx_valid_q, dmx_valid_d;
    logic       frame_done_q, frame_done_d;
    logic       accept;
    logic [2:0] nxt_chan;

    function automatic logic [2:0] lowest_chan(input logic [7:0] en);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Nearest enabled channel after cur, wrapping; falls back to cur itself.
    function automatic logic [2:0] next_chan(input logic [2:0] cur, input logic [7:0] en);
        logic [2:0] r;
        logic [2:0] idx;
        r = cur;
        for (int i = 7; i >= 1; i--) begin
            idx = cur + 3'(i);
            if (en[idx]) r = idx;
        end
        return r;
    endfunction

    assign in_ready = (state_q == RUN) & (|chan_en);
    assign accept   = in_valid & in_ready;
    assign nxt_chan = next_chan(cur_q, chan_en);

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        bcnt_d       = bcnt_q;
        data_in_d    = 1'b0;
        sel_d        = sel_q;
        dmx_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|chan_en) begin
                    state_d = RUN;
                    cur_d   = lowest_chan(chan_en);
                    bcnt_d  = 4'd0;
                end
            end
            RUN: begin
                if (!(|chan_en)) begin
                    state_d = IDLE;
                end else if (accept) begin
                    data_in_d   = in_data;
                    sel_d       = cur_q;
                    dmx_valid_d = 1'b1;
                    if (bcnt_q == BURST_LAST) begin
                        bcnt_d       = 4'd0;
                        cur_d        = nxt_chan;
                        frame_done_d = (nxt_chan <= cur_q);
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= 3'd0;
            bcnt_q       <= 4'd0;
            data_in_q    <= 1'b0;
            sel_q        <= 3'd0;
            dmx_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            bcnt_q       <= bcnt_d;
            data_in_q    <= data_in_d;
            sel_q        <= sel_d;
            dmx_valid_q  <= dmx_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_in    = data_in_q;
    assign sel        = sel_q;
    assign dmx_valid  = dmx_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dmux_rr_scheduler.sv
// tb/tb_dmux_rr_scheduler.sv - directed bench for dmux_rr_scheduler at BURST 1, 2 and 4
module tb_dmux_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic [7:0] chan_en = 8'h00;

    logic       r1_ready, r1_data, r1_valid, r1_done;
    logic [2:0] r1_sel;
    logic       r2_ready, r2_data, r2_valid, r2_done;
    logic [2:0] r2_sel;
    logic       r4_ready, r4_data, r4_valid, r4_done;
    logic [2:0] r4_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmux_rr_scheduler #(.BURST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(r1_ready),
        .chan_en(chan_en), .data_in(r1_data), .sel(r1_sel), .dmx_valid(r1_valid), .frame_done(r1_done)
    );
    dmux_rr_scheduler #(.BURST(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(r2_ready),
        .chan_en(chan_en), .data_in(r2_data), .sel(r2_sel), .dmx_valid(r2_valid), .frame_done(r2_done)
    );
    dmux_rr_scheduler #(.BURST(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(r4_ready),
        .chan_en(chan_en), .data_in(r4_data), .sel(r4_sel), .dmx_valid(r4_valid), .frame_done(r4_done)
    );

    // Reset every instance, then spend the single IDLE cycle so all are in RUN on return.
    task automatic reset_all(input logic [7:0] mask);
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; chan_en = mask;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_data = 1'b1; chan_en = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({r1_ready, r1_data, r1_sel, r1_valid, r1_done} !== 7'd0) begin
                bad++; $display("FAIL reset_b1 cyc%0d got=%b want=0000000", c, {r1_ready, r1_data, r1_sel, r1_valid, r1_done});
            end
            total++;
            if ({r4_ready, r4_data, r4_sel, r4_valid, r4_done} !== 7'd0) begin
                bad++; $display("FAIL reset_b4 cyc%0d got=%b want=0000000", c, {r4_ready, r4_data, r4_sel, r4_valid, r4_done});
            end
        end
        rst = 1'b0; in_valid = 1'b0; #1;
        total++;
        if (r1_ready !== 1'b0) begin bad++; $display("FAIL reset_idle_ready got=%b want=0", r1_ready); end
        @(posedge clk); #1;
        total++;
        if (r1_ready !== 1'b1) begin bad++; $display("FAIL reset_second_cycle_ready got=%b want=1", r1_ready); end
        total++;
        if (r1_valid !== 1'b0) begin bad++; $display("FAIL reset_no_valid got=%b want=0", r1_valid); end
    endtask

    task automatic test_full_sweep;
        logic [7:0] bits;
        bits = 8'b0100_1101;
        reset_all(8'hFF);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = bits[k];
            @(posedge clk); #1;
            total++;
            if (r1_valid !== 1'b1 || r1_sel !== 3'(k) || r1_data !== bits[k]) begin
                bad++; $display("FAIL sweep_bit%0d got v=%b sel=%0d d=%b want v=1 sel=%0d d=%b", k, r1_valid, r1_sel, r1_data, k, bits[k]);
            end
            total++;
            if (r1_done !== (k == 7)) begin
                bad++; $display("FAIL sweep_done%0d got=%b want=%b", k, r1_done, (k == 7));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sparse_mask;
        logic [2:0] exp_sel [8];
        exp_sel = '{3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd2, 3'd2};
        reset_all(8'b1010_0100);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = k[0];
            @(posedge clk); #1;
            total++;
            if (r2_valid !== 1'b1 || r2_sel !== exp_sel[k] || r2_data !== k[0]) begin
                bad++; $display("FAIL sparse_bit%0d got v=%b sel=%0d d=%b want v=1 sel=%0d d=%b", k, r2_valid, r2_sel, r2_data, exp_sel[k], k[0]);
            end
            total++;
            if (r2_done !== (k == 5)) begin
                bad++; $display("FAIL sparse_done%0d got=%b want=%b", k, r2_done, (k == 5));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gaps;
        logic [3:0] vpat;
        logic [2:0] exp_sel [4];
        vpat    = 4'b1001;
        exp_sel = '{3'd0, 3'd0, 3'd0, 3'd1};
        reset_all(8'h0F);
        for (int k = 0; k < 4; k++) begin
            in_valid = vpat[k]; in_data = 1'b1;
            @(posedge clk); #1;
            total++;
            if (r1_valid !== vpat[k] || r1_sel !== exp_sel[k] || r1_data !== vpat[k] || r1_done !== 1'b0) begin
                bad++; $display("FAIL gaps_cyc%0d got v=%b sel=%0d d=%b fd=%b want v=%b sel=%0d d=%b fd=0",
                                k, r1_valid, r1_sel, r1_data, r1_done, vpat[k], exp_sel[k], vpat[k]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_disable_mid_burst;
        logic [2:0] exp_sel [8];
        exp_sel = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
        reset_all(8'h06);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 1'b1;
            @(posedge clk); #1;
            total++;
            if (r4_valid !== 1'b1 || r4_sel !== 3'd1 || r4_done !== 1'b0) begin
                bad++; $display("FAIL dis_pre%0d got v=%b sel=%0d fd=%b want v=1 sel=1 fd=0", k, r4_valid, r4_sel, r4_done);
            end
        end
        chan_en = 8'h00; #1;
        total++;
        if (r4_ready !== 1'b0) begin bad++; $display("FAIL dis_ready_drop got=%b want=0", r4_ready); end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++;
            if (r4_valid !== 1'b0 || r4_done !== 1'b0 || r4_ready !== 1'b0) begin
                bad++; $display("FAIL dis_off%0d got v=%b fd=%b rdy=%b want 0 0 0", c, r4_valid, r4_done, r4_ready);
            end
        end
        chan_en = 8'h06; #1;
        total++;
        if (r4_ready !== 1'b0) begin bad++; $display("FAIL dis_idle_ready got=%b want=0", r4_ready); end
        @(posedge clk); #1;
        total++;
        if (r4_valid !== 1'b0 || r4_ready !== 1'b1) begin
            bad++; $display("FAIL dis_reentry got v=%b rdy=%b want v=0 rdy=1", r4_valid, r4_ready);
        end
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = k[1];
            @(posedge clk); #1;
            total++;
            if (r4_valid !== 1'b1 || r4_sel !== exp_sel[k] || r4_data !== k[1]) begin
                bad++; $display("FAIL dis_bit%0d got v=%b sel=%0d d=%b want v=1 sel=%0d d=%b", k, r4_valid, r4_sel, r4_data, exp_sel[k], k[1]);
            end
            total++;
            if (r4_done !== (k == 7)) begin
                bad++; $display("FAIL dis_done%0d got=%b want=%b", k, r4_done, (k == 7));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single_channel;
        reset_all(8'h10);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = ~k[0];
            @(posedge clk); #1;
            total++;
            if (r1_valid !== 1'b1 || r1_sel !== 3'd4 || r1_done !== 1'b1 || r1_data !== ~k[0]) begin
                bad++; $display("FAIL single_bit%0d got v=%b sel=%0d fd=%b d=%b want v=1 sel=4 fd=1 d=%b",
                                k, r1_valid, r1_sel, r1_done, r1_data, ~k[0]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (r1_valid !== 1'b0 || r1_done !== 1'b0 || r1_sel !== 3'd4) begin
            bad++; $display("FAIL single_idle got v=%b fd=%b sel=%0d want v=0 fd=0 sel=4", r1_valid, r1_done, r1_sel);
        end
    endtask

    initial begin
        test_reset;
        test_full_sweep;
        test_sparse_mask;
        test_gaps;
        test_disable_mid_burst;
        test_single_channel;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
